// File: rtl/irq_vector_responder.sv
// IM2-style interrupt responder: holds pending requests, raises int_n, answers the CPU
// acknowledge cycle with a vector byte and pulses a one-hot ack back to the serviced source.
module irq_vector_responder #(
    parameter int          INPUT_QTY   = 8,
    parameter logic [7:0]  VECTOR_BASE = 8'h00,
    localparam int         IDXW        = $clog2(INPUT_QTY)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [INPUT_QTY-1:0] req_pulse,
    output logic [INPUT_QTY-1:0] pend,
    input  logic                 enc_valid,
    input  logic [IDXW-1:0]      enc_idx,
    input  logic                 m1_n,
    input  logic                 iorq_n,
    output logic                 int_n,
    output logic [7:0]           vec_data,
    output logic                 vec_oe,
    output logic [INPUT_QTY-1:0] ack
);

    // state | meaning
    // IDLE  | no request to CPU; evaluate encoder
    // REQ   | int_n asserted; waiting for M1+IORQ acknowledge
    // VEC   | vector driven on bus until IORQ releases
    // DONE  | ack serviced source, clear its pending bit
    typedef enum logic [1:0] {IDLE, REQ, VEC, DONE} state_t;

    state_t                 state_q;
    logic [IDXW-1:0]        idx_q;
    logic [INPUT_QTY-1:0]   pend_q, pend_d;
    logic [INPUT_QTY-1:0]   idx_mask;
    logic [INPUT_QTY-1:0]   ack_q;
    logic                   int_n_q;
    logic                   vec_oe_q;
    logic [7:0]             vec_data_q, vec_data_d;
    logic [7:0]             idx_x;

    // An out-of-range index (non-power-of-two INPUT_QTY) matches no bit, so it
    // neither acks nor clears anything.
    always_comb begin
        idx_mask = '0;
        for (int i = 0; i < INPUT_QTY; i++) begin
            if (idx_q == IDXW'(i)) begin
                idx_mask[i] = 1'b1;
            end
        end
    end

    assign idx_x      = 8'(idx_q);
    assign vec_data_d = VECTOR_BASE + {idx_x[6:0], 1'b0};

    // New request strobes are OR'd in after the clear so a coincident set wins.
    assign pend_d = (pend_q & ~((state_q == DONE) ? idx_mask : '0)) | req_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            idx_q      <= '0;
            int_n_q    <= 1'b1;
            vec_oe_q   <= 1'b0;
            vec_data_q <= 8'h00;
            ack_q      <= '0;
        end else begin
            pend_q   <= pend_d;
            int_n_q  <= (state_q != REQ);
            vec_oe_q <= (state_q == VEC);
            ack_q    <= (state_q == DONE) ? idx_mask : '0;
            if (state_q == VEC) begin
                vec_data_q <= vec_data_d;
            end
            case (state_q)
                IDLE: begin
                    if (ena && enc_valid) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!ena || !enc_valid) begin
                        state_q <= IDLE;
                    end else if (!m1_n && !iorq_n) begin
                        idx_q   <= enc_idx;
                        state_q <= VEC;
                    end
                end
                VEC: begin
                    if (iorq_n) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pend     = pend_q;
    assign int_n    = int_n_q;
    assign vec_oe   = vec_oe_q;
    assign vec_data = vec_data_q;
    assign ack      = ack_q;

endmodule

// File: tb/tb_irq_vector_responder.sv
// Scoreboard bench for irq_vector_responder: three instances (N=8 base 40, N=8 base FC,
// N=6 base 40) sharing the CPU bus strobes; a monitor checks every vector and ack.
module tb_irq_vector_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena, m1_n, iorq_n;

    logic [7:0] req_m, pend_m, ack_m, vd_m;
    logic       ev_m, int_m, voe_m;
    logic [2:0] ei_m;

    logic [7:0] req_w, pend_w, ack_w, vd_w;
    logic       ev_w, int_w, voe_w;
    logic [2:0] ei_w;

    logic [5:0] req_s, pend_s, ack_s;
    logic [7:0] vd_s;
    logic       ev_s, int_s, voe_s;
    logic [2:0] ei_s;
    logic [3:0] enc_s;
    logic       force_s;

    // Priority encoder model: highest set bit wins.
    function automatic logic [3:0] enc(input logic [7:0] p);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign {ev_m, ei_m} = enc(pend_m);
    assign {ev_w, ei_w} = enc(pend_w);
    assign enc_s = enc({2'b00, pend_s});
    assign ev_s  = force_s ? 1'b1 : enc_s[3];
    assign ei_s  = force_s ? 3'd7 : enc_s[2:0];

    irq_vector_responder #(.INPUT_QTY(8), .VECTOR_BASE(8'h40)) u_m (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_pulse(req_m), .pend(pend_m),
        .enc_valid(ev_m), .enc_idx(ei_m), .m1_n(m1_n), .iorq_n(iorq_n),
        .int_n(int_m), .vec_data(vd_m), .vec_oe(voe_m), .ack(ack_m));

    irq_vector_responder #(.INPUT_QTY(8), .VECTOR_BASE(8'hFC)) u_w (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_pulse(req_w), .pend(pend_w),
        .enc_valid(ev_w), .enc_idx(ei_w), .m1_n(m1_n), .iorq_n(iorq_n),
        .int_n(int_w), .vec_data(vd_w), .vec_oe(voe_w), .ack(ack_w));

    irq_vector_responder #(.INPUT_QTY(6), .VECTOR_BASE(8'h40)) u_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_pulse(req_s), .pend(pend_s),
        .enc_valid(ev_s), .enc_idx(ei_s), .m1_n(m1_n), .iorq_n(iorq_n),
        .int_n(int_s), .vec_data(vd_s), .vec_oe(voe_s), .ack(ack_s));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         inst;
        logic [7:0] vec;
        logic [7:0] ack;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic       voe_v[3];
    logic [7:0] vd_v[3], ack_v[3];
    logic       prev[3], armed[3];
    logic [7:0] due[3], held[3];

    always_comb begin
        voe_v[0] = voe_m;  vd_v[0] = vd_m;  ack_v[0] = ack_m;
        voe_v[1] = voe_w;  vd_v[1] = vd_w;  ack_v[1] = ack_w;
        voe_v[2] = voe_s;  vd_v[2] = vd_s;  ack_v[2] = {2'b00, ack_s};
    end

    // Monitor: vec_oe rise pops an expectation; vec_oe fall must coincide with the ack.
    initial begin
        for (int i = 0; i < 3; i++) begin
            prev[i] = 1'b0; armed[i] = 1'b0; due[i] = '0; held[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    prev[i]  = 1'b0;
                    armed[i] = 1'b0;
                end else begin
                    if (voe_v[i] && !prev[i]) begin
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_vector: inst %0d drove %0h with nothing expected", i, vd_v[i]);
                        end else begin
                            e = sb.pop_front();
                            chk("service_inst", i, e.inst);
                            chk("vec_data", vd_v[i], e.vec);
                            due[i]   = e.ack;
                            armed[i] = 1'b1;
                            held[i]  = vd_v[i];
                        end
                    end else if (voe_v[i] && vd_v[i] !== held[i]) begin
                        checks++; errors++;
                        $display("FAIL vec_data_hold: inst %0d got %0h expected %0h", i, vd_v[i], held[i]);
                    end
                    if (!voe_v[i] && prev[i] && armed[i]) begin
                        chk("ack", ack_v[i], due[i]);
                        armed[i] = 1'b0;
                    end else if (ack_v[i] !== 8'h00) begin
                        checks++; errors++;
                        $display("FAIL stray_ack: inst %0d got %0h expected 0", i, ack_v[i]);
                    end
                    prev[i] = voe_v[i];
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic get_int(input int inst);
        case (inst)
            0:       return int_m;
            1:       return int_w;
            default: return int_s;
        endcase
    endfunction

    task automatic wait_int(input int inst, input string name);
        int   k;
        logic v;
        k = 0;
        v = get_int(inst);
        while (v !== 1'b0 && k < 20) begin
            step(1);
            k++;
            v = get_int(inst);
        end
        chk(name, v, 1'b0);
    endtask

    // CPU acknowledge: M1+IORQ low for three edges, then release. Optionally drop ena
    // during the vector phase, or re-pulse source 3 of the wrap instance on the clear edge.
    task automatic bus_ack(input logic drop_ena, input logic repulse);
        m1_n = 1'b0; iorq_n = 1'b0;
        step(1);
        if (drop_ena) ena = 1'b0;
        step(2);
        m1_n = 1'b1; iorq_n = 1'b1;
        step(1);
        if (repulse) req_w = 8'h08;
        step(1);
        req_w = 8'h00;
        step(1);
        if (drop_ena) ena = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
        req_m = '0; req_w = '0; req_s = '0; force_s = 1'b0;
        step(2);
        chk("rst_int_n", int_m, 1'b1);
        chk("rst_vec_oe", voe_m, 1'b0);
        chk("rst_vec_data", vd_m, 8'h00);
        chk("rst_ack", ack_m, 8'h00);
        chk("rst_pend", pend_m, 8'h00);
        rst_n = 1'b1;
        step(2);
        ena = 1'b1;

        // Single source 3, base 40: latency and vector 46.
        req_m = 8'h08; step(1); req_m = 8'h00;
        chk("pend_set", pend_m, 8'h08);
        chk("int_n_early0", int_m, 1'b1);
        step(1);
        chk("int_n_early1", int_m, 1'b1);
        step(1);
        chk("int_n_latency", int_m, 1'b0);
        sb.push_back('{0, 8'h46, 8'h08});
        bus_ack(1'b0, 1'b0);
        step(1);
        chk("pend_cleared", pend_m, 8'h00);
        chk("int_n_idle", int_m, 1'b1);

        // Sources 1 and 5 together: 5 first, then 1.
        req_m = 8'h22; step(1); req_m = 8'h00;
        chk("pend_two", pend_m, 8'h22);
        wait_int(0, "int_n_first");
        sb.push_back('{0, 8'h4A, 8'h20});
        bus_ack(1'b0, 1'b0);
        wait_int(0, "int_n_reassert");
        sb.push_back('{0, 8'h42, 8'h02});
        bus_ack(1'b0, 1'b0);
        step(1);
        chk("pend_two_cleared", pend_m, 8'h00);

        // ena dropped in REQ, then dropped during VEC.
        req_m = 8'h04; step(1); req_m = 8'h00;
        wait_int(0, "int_n_src2");
        ena = 1'b0;
        step(2);
        chk("int_n_ena_drop", int_m, 1'b1);
        chk("pend_kept_ena_drop", pend_m, 8'h04);
        ena = 1'b1;
        wait_int(0, "int_n_ena_restore");
        sb.push_back('{0, 8'h44, 8'h04});
        bus_ack(1'b1, 1'b0);
        step(1);
        chk("pend_after_ena_vec", pend_m, 8'h00);

        // Base FC wrap; re-pulse on the clear edge keeps the bit.
        req_w = 8'h08; step(1); req_w = 8'h00;
        wait_int(1, "int_n_wrap");
        sb.push_back('{1, 8'h02, 8'h08});
        bus_ack(1'b0, 1'b1);
        chk("pend_set_wins", pend_w, 8'h08);
        wait_int(1, "int_n_wrap_reassert");
        sb.push_back('{1, 8'h02, 8'h08});
        bus_ack(1'b0, 1'b0);
        step(1);
        chk("pend_wrap_cleared", pend_w, 8'h00);

        // Asynchronous reset while the vector is driven.
        req_m = 8'h40; step(1); req_m = 8'h00;
        wait_int(0, "int_n_src6");
        sb.push_back('{0, 8'h4C, 8'h40});
        m1_n = 1'b0; iorq_n = 1'b0;
        step(2);
        @(negedge clk); #1;
        chk("vec_oe_before_rst", voe_m, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vec_oe", voe_m, 1'b0);
        chk("async_rst_int_n", int_m, 1'b1);
        chk("async_rst_pend", pend_m, 8'h00);
        chk("async_rst_ack", ack_m, 8'h00);
        chk("async_rst_vec_data", vd_m, 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("post_rst_int_n", int_m, 1'b1);
        chk("post_rst_vec_oe", voe_m, 1'b0);
        chk("post_rst_pend", pend_m, 8'h00);

        // N=6 with encoder forced to index 7: vector 4E, no ack, pend untouched.
        req_s = 6'h04; step(1); req_s = 6'h00;
        force_s = 1'b1;
        wait_int(2, "int_n_n6");
        sb.push_back('{2, 8'h4E, 8'h00});
        bus_ack(1'b0, 1'b0);
        chk("pend_no_clear_oob", pend_s, 6'h04);
        force_s = 1'b0;
        ena = 1'b0;
        step(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
